// File: rtl/jtcps1_vram_arb.sv
// jtcps1_vram_arb: shares the VRAM DMA read port between the tile, palette and
// object fetchers. The CPU bus is taken through br/bg, then one word is read at
// a time and returned to the winning requester with a single-cycle ack.
module jtcps1_vram_arb #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TW      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [16:0] addr0,
    input  logic [16:0] addr1,
    input  logic [16:0] addr2,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [15:0] dout,
    output logic        br,
    input  logic        bg,
    output logic [16:0] vram_addr,
    output logic        vram_cs,
    output logic        vram_clr,
    input  logic [15:0] vram_data,
    input  logic        vram_ok
);
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 16;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BUSREQ = 3'd1;
    localparam logic [2:0] ISSUE  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]    state,     state_nxt;
    logic [NR-1:0] gnt_nxt,   ack_nxt;
    logic [DW-1:0] dout_nxt;
    logic          br_nxt;
    logic [AW-1:0] addr_nxt;
    logic          cs_nxt,    clr_nxt;
    logic [TW-1:0] cnt,       cnt_nxt;
    logic          reload,    reload_nxt;

    logic [NR-1:0] win;
    logic [AW-1:0] win_addr;
    logic [AW-1:0] own_addr;

    // Fixed priority pick among pending requests: tile > pal > obj
    always_comb begin
        win      = '0;
        win_addr = addr2;
        if (req[0]) begin
            win      = NR'(3'b001);
            win_addr = addr0;
        end else if (req[1]) begin
            win      = NR'(3'b010);
            win_addr = addr1;
        end else if (req[2]) begin
            win      = NR'(3'b100);
            win_addr = addr2;
        end
    end

    // Address of the current owner, used to refresh a re-granted address
    always_comb begin
        own_addr = addr2;
        if (gnt[0]) begin
            own_addr = addr0;
        end else if (gnt[1]) begin
            own_addr = addr1;
        end
    end

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            ack       <= '0;
            dout      <= '0;
            br        <= 1'b0;
            vram_addr <= '0;
            vram_cs   <= 1'b0;
            vram_clr  <= 1'b0;
            cnt       <= '0;
            reload    <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            ack       <= ack_nxt;
            dout      <= dout_nxt;
            br        <= br_nxt;
            vram_addr <= addr_nxt;
            vram_cs   <= cs_nxt;
            vram_clr  <= clr_nxt;
            cnt       <= cnt_nxt;
            reload    <= reload_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        ack_nxt    = '0;
        dout_nxt   = dout;
        br_nxt     = br;
        addr_nxt   = vram_addr;
        cs_nxt     = vram_cs;
        clr_nxt    = 1'b0;
        cnt_nxt    = cnt;
        reload_nxt = 1'b0;

        case (state)
            IDLE: begin
                cs_nxt = 1'b0;
                if (req != '0) begin
                    gnt_nxt   = win;
                    addr_nxt  = win_addr;
                    br_nxt    = 1'b1;
                    state_nxt = BUSREQ;
                end else begin
                    gnt_nxt = '0;
                    br_nxt  = 1'b0;
                end
            end
            BUSREQ: begin
                br_nxt = 1'b1;
                // A requester re-granted at DONE may present its next address one cycle late
                if (reload) begin
                    addr_nxt = own_addr;
                end
                if (bg) begin
                    cs_nxt    = 1'b1;
                    clr_nxt   = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    cs_nxt     = 1'b0;
                    reload_nxt = reload;
                end
            end
            ISSUE: begin
                if (!bg) begin
                    cs_nxt    = 1'b0;
                    state_nxt = BUSREQ;
                end else begin
                    cs_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!bg) begin
                    cs_nxt    = 1'b0;
                    state_nxt = BUSREQ;
                end else if (vram_ok) begin
                    dout_nxt  = vram_data;
                    ack_nxt   = gnt;
                    cs_nxt    = 1'b0;
                    state_nxt = DONE;
                end else if (cnt == TW'(TIMEOUT)) begin
                    clr_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ISSUE;
                end else begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
            DONE: begin
                cs_nxt = 1'b0;
                if (req != '0) begin
                    gnt_nxt    = win;
                    addr_nxt   = win_addr;
                    reload_nxt = 1'b1;
                    state_nxt  = BUSREQ;
                end else begin
                    gnt_nxt   = '0;
                    br_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                br_nxt    = 1'b0;
                cs_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
